bcd_time_of_day: RTL and testbench
==================================

// Module: bcd_time_of_day
// PURPOSE
//  Downstream consumer of the CLOCK_10MHz divider chain.
//  - Samples the divider's CLOCK_1Hz output in the CLOCK_10MHz domain and turns its rising edge into a one-cycle tick.
//  - Keeps a 24-hour HH:MM:SS time in packed BCD for display drivers.
//  - Supports run/hold and a validated parallel time load.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages on CLOCK_1Hz before edge detect (legal values: 2 or more)
// PORTS
//  CLOCK_10MHz  in   1  system clock; the only clock in this block
//  RESET_N      in   1  reset, asynchronous, active-low
//  CLOCK_1Hz    in   1  divided clock from the divider; treated as a data input, never used as a clock
//  RUN          in   1  1 = count on ticks; 0 = hold the time
//  LOAD         in   1  one-cycle request to load LOAD_HH/LOAD_MM/LOAD_SS
//  LOAD_HH      in   8  BCD hours {tens,units}
//  LOAD_MM      in   8  BCD minutes
//  LOAD_SS      in   8  BCD seconds
//  HH           out  8  current hours, BCD 00-23
//  MM           out  8  current minutes, BCD 00-59
//  SS           out  8  current seconds, BCD 00-59
//  SEC_PULSE    out  1  one-cycle pulse for each second counted
//  ROLLOVER     out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition
//  LOAD_ERR     out  1  one-cycle pulse when a load request is rejected
// BEHAVIOUR
//  Reset
//  - All outputs are registered.
//  - Reset values: HH=MM=SS=8'h00; SEC_PULSE=ROLLOVER=LOAD_ERR=0; synchronizer and edge-detect flops cleared to 0.
//  - Reset mid-operation clears the time at once, regardless of clock.
//  Tick generation
//  - tick = sync_out & ~sync_q.
//  - A CLOCK_1Hz rise first sampled at edge k gives tick high in the cycle after edge k+SYNC_STAGES-1.
//  - The time update is visible after edge k+SYNC_STAGES.
//  - Exactly one tick per CLOCK_1Hz rising edge. No tick on a falling edge.
//  - If CLOCK_1Hz is already 1 at reset release, exactly one tick is produced; this is intended.
//  Priority in one cycle: LOAD > tick.
//  - LOAD with valid data: HH/MM/SS take the load values on the next edge.
//    - A tick in the same cycle is discarded.
//    - SEC_PULSE and ROLLOVER stay 0 for that cycle.
//  - LOAD with invalid data: time is unchanged, LOAD_ERR=1 for one cycle, and a tick in the same cycle is discarded.
//    - Data is invalid if any units nibble > 9, tens of MM or SS > 5, or hours > 23 (tens > 2, or tens = 2 and units > 3).
//  - tick & RUN & ~LOAD: the time advances by one second and SEC_PULSE=1 on the same edge.
//  - RUN=0: ticks are dropped. The edge detector keeps tracking, so there is no catch-up burst on resume.
//  Counting (per-digit BCD, carry ripples within one cycle)
//  - SS units 0-9, then SS tens 0-5, then carry into MM.
//  - MM units 0-9, then MM tens 0-5, then carry into HH.
//  - HH units wrap 9 -> 0 with tens+1, except 23 -> 00.
//  - 23:59:59 + tick -> 00:00:00, with ROLLOVER=1 and SEC_PULSE=1 on the same edge.
//  Invariant: outputs never hold a non-BCD or out-of-range value.
// STRUCTURE
//  time_pkg
//  - typedef logic [3:0] bcd_t.
//  - typedef struct packed {bcd_t tens, units;} bcd2_t.
//  - Constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, HR_MAX=8'h23.
//  - function bcd2_valid(bcd2_t v, bcd2_t max).
//  Sub-module sync_edge_detect #(SYNC_STAGES)
//  - Inputs: CLOCK_10MHz, RESET_N, async_in.
//  - Output: rise_pulse.
//  - Reused later for pushbutton inputs.
//  Top level: load validation, BCD counter cascade, pulse registers.
// TESTING
//  1. Release reset with CLOCK_1Hz=0, RUN=1, then one CLOCK_1Hz rise -> SS=8'h01 after SYNC_STAGES+1 cycles; SEC_PULSE high exactly 1 cycle.
//  2. LOAD 23:59:58, then 2 rises -> 23:59:59, then 00:00:00; ROLLOVER pulses only on the second rise.
//  3. LOAD 12:34:56 in the same cycle as a tick -> 12:34:56 with no increment; SEC_PULSE=0.
//  4. LOAD 24:00:00, then 12:60:00, then 12:0A:00 -> time unchanged each time; LOAD_ERR pulses 1 cycle each time.
//  5. RUN=0 across 3 rises, then RUN=1 and 1 rise -> time advances by exactly 1 s.
//  6. Assert RESET_N low between clock edges at 09:59:59 -> outputs become 00:00:00 at once.
//     Release with CLOCK_1Hz=1 -> exactly one tick, giving 00:00:01.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: shared BCD types, range limits and a digit-pair validity check
// for the time-of-day counter and anything that loads or displays its values.
package time_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  localparam bcd_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_t  MIN_TENS_MAX = 4'd5;
  localparam bcd_t  UNITS_MAX    = 4'd9;
  localparam bcd2_t HR_MAX       = 8'h23;
  localparam bcd2_t SEC_MAX      = '{tens: SEC_TENS_MAX, units: UNITS_MAX};
  localparam bcd2_t MIN_MAX      = '{tens: MIN_TENS_MAX, units: UNITS_MAX};

  // True when v is a legal BCD pair no greater than max (max is itself BCD).
  function automatic logic bcd2_valid(bcd2_t v, bcd2_t max);
    logic units_ok;
    logic range_ok;
    units_ok = (v.units <= UNITS_MAX);
    range_ok = (v.tens < max.tens) ||
               ((v.tens == max.tens) && (v.units <= max.units));
    return units_ok && range_ok;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the CLOCK_10MHz domain
// through a SYNC_STAGES flop chain and emits a one-cycle pulse on each rise.
// Ports:
//   CLOCK_10MHz  system clock
//   RESET_N      asynchronous active-low reset (clears all flops)
//   async_in     asynchronous level input
//   rise_pulse   high for one cycle after each synchronised 0->1 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLOCK_10MHz,
  input  logic RESET_N,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic                   sync_out;

  assign sync_out = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_chain <= '0;
      sync_q     <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      sync_q     <= sync_out;
    end
  end

  assign rise_pulse = sync_out & ~sync_q;

endmodule

// File: rtl/bcd_time_of_day.sv
// bcd_time_of_day: 24-hour HH:MM:SS counter in packed BCD, advanced by the
// rising edges of CLOCK_1Hz (sampled as data in the CLOCK_10MHz domain).
// Ports:
//   CLOCK_10MHz        system clock
//   RESET_N            asynchronous active-low reset
//   CLOCK_1Hz          seconds strobe level from the divider
//   RUN                1 = count, 0 = hold
//   LOAD               one-cycle load request for LOAD_HH/LOAD_MM/LOAD_SS
//   LOAD_HH/MM/SS      BCD load values
//   HH/MM/SS           current time, BCD
//   SEC_PULSE          one-cycle pulse per counted second
//   ROLLOVER           one-cycle pulse on 23:59:59 -> 00:00:00
//   LOAD_ERR           one-cycle pulse when a load is rejected
module bcd_time_of_day
  import time_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLOCK_10MHz,
  input  logic       RESET_N,
  input  logic       CLOCK_1Hz,
  input  logic       RUN,
  input  logic       LOAD,
  input  logic [7:0] LOAD_HH,
  input  logic [7:0] LOAD_MM,
  input  logic [7:0] LOAD_SS,
  output logic [7:0] HH,
  output logic [7:0] MM,
  output logic [7:0] SS,
  output logic       SEC_PULSE,
  output logic       ROLLOVER,
  output logic       LOAD_ERR
);

  logic  tick;
  logic  load_ok;
  logic  wrap;
  bcd2_t hh, mm, ss;
  bcd2_t hh_n, mm_n, ss_n;
  logic  sec_pulse, rollover, load_err;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLOCK_10MHz(CLOCK_10MHz),
    .RESET_N    (RESET_N),
    .async_in   (CLOCK_1Hz),
    .rise_pulse (tick)
  );

  assign load_ok = bcd2_valid(LOAD_HH, HR_MAX) &
                   bcd2_valid(LOAD_MM, MIN_MAX) &
                   bcd2_valid(LOAD_SS, SEC_MAX);

  // One-second increment; carries ripple through all six digits combinationally.
  always_comb begin
    ss_n = ss;
    mm_n = mm;
    hh_n = hh;
    wrap = 1'b0;
    if (ss.units != UNITS_MAX) begin
      ss_n.units = ss.units + 4'd1;
    end else begin
      ss_n.units = '0;
      if (ss.tens != SEC_TENS_MAX) begin
        ss_n.tens = ss.tens + 4'd1;
      end else begin
        ss_n.tens = '0;
        if (mm.units != UNITS_MAX) begin
          mm_n.units = mm.units + 4'd1;
        end else begin
          mm_n.units = '0;
          if (mm.tens != MIN_TENS_MAX) begin
            mm_n.tens = mm.tens + 4'd1;
          end else begin
            mm_n.tens = '0;
            if (hh == HR_MAX) begin
              hh_n = '0;
              wrap = 1'b1;
            end else if (hh.units == UNITS_MAX) begin
              hh_n.units = '0;
              hh_n.tens  = hh.tens + 4'd1;
            end else begin
              hh_n.units = hh.units + 4'd1;
            end
          end
        end
      end
    end
  end

  // LOAD wins over a coincident tick, whether or not the load is accepted.
  always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      hh        <= '0;
      mm        <= '0;
      ss        <= '0;
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
      load_err  <= 1'b0;
      if (LOAD) begin
        if (load_ok) begin
          hh <= LOAD_HH;
          mm <= LOAD_MM;
          ss <= LOAD_SS;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick && RUN) begin
        hh        <= hh_n;
        mm        <= mm_n;
        ss        <= ss_n;
        sec_pulse <= 1'b1;
        rollover  <= wrap;
      end
    end
  end

  assign HH        = hh;
  assign MM        = mm;
  assign SS        = ss;
  assign SEC_PULSE = sec_pulse;
  assign ROLLOVER  = rollover;
  assign LOAD_ERR  = load_err;

endmodule

// File: tb/tb_bcd_time_of_day.sv
// Scoreboard bench for bcd_time_of_day: a seconds-of-day reference model
// pushes the expected outputs for every clock edge; a monitor pops and
// compares them on the following falling edge.
module tb_bcd_time_of_day;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c1 = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lhh = '0, lmm = '0, lss = '0;
  logic [7:0] HH, MM, SS;
  logic       SEC_PULSE, ROLLOVER, LOAD_ERR;

  bcd_time_of_day #(.SYNC_STAGES(S)) dut (
    .CLOCK_10MHz(clk),
    .RESET_N    (rst_n),
    .CLOCK_1Hz  (c1),
    .RUN        (run),
    .LOAD       (load),
    .LOAD_HH    (lhh),
    .LOAD_MM    (lmm),
    .LOAD_SS    (lss),
    .HH         (HH),
    .MM         (MM),
    .SS         (SS),
    .SEC_PULSE  (SEC_PULSE),
    .ROLLOVER   (ROLLOVER),
    .LOAD_ERR   (LOAD_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hh, mm, ss;
    logic       sec, roll, err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: time as seconds since midnight, and the history
  // of CLOCK_1Hz values seen at previous edges (index 0 = most recent).
  int   m_secs = 0;
  int   hist[$];

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int dec(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_valid(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    if (h[3:0] > 9 || m[3:0] > 9 || s[3:0] > 9) return 1'b0;
    if (m[7:4] > 5 || s[7:4] > 5) return 1'b0;
    return dec(h) <= 23;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Reference model: one expectation per clock edge.
  always @(posedge clk) begin
    exp_t e;
    bit   tick;
    e.sec  = 1'b0;
    e.roll = 1'b0;
    e.err  = 1'b0;
    if (!rst_n) begin
      m_secs = 0;
      hist.delete();
      for (int i = 0; i <= int'(S); i++) hist.push_back(0);
    end else begin
      // A rise first seen S edges ago produces the update at this edge.
      tick = (hist[S-1] == 1) && (hist[S] == 0);
      if (load) begin
        if (load_valid(lhh, lmm, lss))
          m_secs = dec(lhh) * 3600 + dec(lmm) * 60 + dec(lss);
        else
          e.err = 1'b1;
      end else if (tick && run) begin
        m_secs = (m_secs + 1) % 86400;
        e.sec  = 1'b1;
        e.roll = (m_secs == 0);
      end
      hist.push_front(int'(c1));
      void'(hist.pop_back());
    end
    e.hh = to_bcd(m_secs / 3600);
    e.mm = to_bcd((m_secs / 60) % 60);
    e.ss = to_bcd(m_secs % 60);
    sbq.push_back(e);
  end

  // Monitor: compare DUT outputs against the expectation for the last edge.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("hh", HH, e.hh);
      chk("mm", MM, e.mm);
      chk("ss", SS, e.ss);
      chk("sec_pulse", {7'd0, SEC_PULSE}, {7'd0, e.sec});
      chk("rollover",  {7'd0, ROLLOVER},  {7'd0, e.roll});
      chk("load_err",  {7'd0, LOAD_ERR},  {7'd0, e.err});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise_c1();
    c1 = 1'b1;
    cyc(4);
    c1 = 1'b0;
    cyc(4);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    lhh  = h;
    lmm  = m;
    lss  = s;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int hold;
    int r;
    rst_n = 1'b0;
    run   = 1'b1;
    c1    = 1'b0;
    cyc(3);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Single second from reset.
    rise_c1();
    cyc(2);

    // Rollover across midnight.
    do_load(8'h23, 8'h59, 8'h58);
    rise_c1();
    rise_c1();

    // Load coincident with a tick: tick is discarded.
    c1 = 1'b1;
    cyc(S);
    do_load(8'h12, 8'h34, 8'h56);
    cyc(3);
    c1 = 1'b0;
    cyc(3);

    // Rejected loads.
    do_load(8'h24, 8'h00, 8'h00);
    cyc(2);
    do_load(8'h12, 8'h60, 8'h00);
    cyc(2);
    do_load(8'h12, 8'h0A, 8'h00);
    cyc(2);
    do_load(8'h1A, 8'h00, 8'h00);
    cyc(2);

    // Hold while RUN=0, then resume without catch-up.
    run = 1'b0;
    repeat (3) rise_c1();
    run = 1'b1;
    rise_c1();

    // Asynchronous reset between edges, released with CLOCK_1Hz already high.
    do_load(8'h09, 8'h59, 8'h59);
    cyc(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hh", HH, 8'h00);
    chk("async_rst_mm", MM, 8'h00);
    chk("async_rst_ss", SS, 8'h00);
    c1 = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(8);
    c1 = 1'b0;
    cyc(4);

    // Randomised traffic.
    hold = 1;
    repeat (4000) begin
      hold--;
      if (hold <= 0) begin
        c1   = ~c1;
        hold = int'($urandom_range(1, 6));
      end
      run = ($urandom_range(0, 15) != 0);
      r = int'($urandom_range(0, 59));
      if (r == 0) begin
        lhh = to_bcd(int'($urandom_range(0, 23)));
        lmm = to_bcd(int'($urandom_range(0, 59)));
        lss = to_bcd(int'($urandom_range(0, 59)));
        load = 1'b1;
      end else if (r == 1) begin
        lhh = 8'($urandom);
        lmm = 8'($urandom);
        lss = 8'($urandom);
        load = 1'b1;
      end else if (r == 2) begin
        lhh = ($urandom_range(0, 1) != 0) ? 8'h23 : 8'h19;
        lmm = 8'h59;
        lss = to_bcd(int'($urandom_range(55, 59)));
        load = 1'b1;
      end
      cyc(1);
      load = 1'b0;
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
